level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Game-level controller; the initiator side of the destination-rectangle interface.
- Drives the destination rectangle's position, colour and visibility for the current level.
- Consumes the one-cycle level-complete pulse that comes back from the rectangle detector.
- Runs an inter-level hold period, advances the level, re-arms the player, and flags game completion after the last level.

Parameters:
- NUM_LEVELS, 8, number of levels; legal range 1..16.
- HOLD_CYCLES, 25000000, cycles the rectangle stays hidden between levels; must be >= 1.
- CNT_W, 25, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- start  in  1  level-sensitive start/restart request.
- level_complete  in  1  one-cycle pulse from the rectangle detector.
- vStartPos  out  10  rectangle vertical position for the current level.
- hStartPos  out  10  rectangle horizontal position for the current level.
- rect_color  out  4  rectangle colour.
- visible  out  1  rectangle visible.
- level  out  4  current level index, 0-based.
- player_reset  out  1  one-cycle pulse; returns the player to its spawn point.
- in_transition  out  1  high during the inter-level hold.
- game_won  out  1  high after the final level completes.

Behaviour:
- All outputs are registered. Reset (rst=0 at a clock edge) gives:
  - state=IDLE, level=0, visible=0, player_reset=0, in_transition=0, game_won=0
  - hold counter=0, hStartPos=64, vStartPos=400, rect_color=1
- Reset has priority over every other input and aborts any state, including mid-hold.
- Position, colour and level are a pure function of the level register L (10-bit unsigned arithmetic, no overflow for L<=7):
  - hStartPos = 64 + 72*L
  - vStartPos = 400 - 40*L
  - rect_color = L+1
- For NUM_LEVELS > 8, levels 8..15 reuse the table at L-8, but colour stays L+1 truncated to 4 bits.
- States:
  - IDLE: visible=0. start=1 -> PLAY; in the same edge, player_reset=1 for exactly one cycle and level=0.
  - PLAY: visible=1. level_complete=1 -> HOLD; at the next edge visible=0, in_transition=1, counter=0. start is ignored in PLAY.
  - HOLD: visible=0, in_transition=1, counter increments each cycle.
    - HOLD lasts exactly HOLD_CYCLES cycles.
    - When counter==HOLD_CYCLES-1 and L<NUM_LEVELS-1: go to PLAY, set L=L+1, pulse player_reset, clear in_transition. New position and colour appear in the same cycle visible returns to 1.
    - When counter==HOLD_CYCLES-1 and L==NUM_LEVELS-1: go to DONE, game_won=1, in_transition=0. L stays at NUM_LEVELS-1.
  - DONE: visible=0, game_won=1. start=1 -> L=0, game_won=0, PLAY, player_reset pulse (same as from IDLE).
- level_complete is ignored in IDLE, HOLD and DONE.
  - A pulse arriving in the same cycle as the HOLD->PLAY transition is dropped.
  - No pending/latched completion is kept.
- Because the detector only pulses on a rising match, a player still on the old target cannot re-trigger. The player_reset pulse guarantees the player is moved.
- player_reset is never high for more than one consecutive cycle.
- Undefined state encodings recover to IDLE on the next edge, with outputs as at reset.

Test Plan (HOLD_CYCLES=4, NUM_LEVELS=3 unless noted):
- Reset and start: hold rst=0 for 2 cycles, then release.
  - Expect visible=0, level=0, h=64, v=400, color=1.
  - Then start=1 for 1 cycle -> next edge visible=1 and player_reset=1 for exactly 1 cycle.
- Level advance: in PLAY, level_complete pulse at cycle t.
  - Cycles t+1..t+4: visible=0, in_transition=1.
  - Cycle t+5: visible=1, level=1, h=136, v=360, color=2, player_reset=1 for 1 cycle.
- Game won: complete levels 0, 1, 2.
  - After the last hold: game_won=1, visible=0, level=2.
  - Then start -> level=0, game_won=0, visible=1.
- Ignored inputs:
  - level_complete pulses during IDLE, HOLD and DONE cause no change; the hold is still exactly 4 cycles.
  - start during PLAY causes no change.
  - level_complete coincident with the HOLD->PLAY edge is dropped, and the level stays at the new value.
- Mid-operation reset: assert rst=0 at hold count 2 of level 1 -> next edge IDLE, level=0, h=64, v=400, in_transition=0.
- NUM_LEVELS=8, level 7 check: h=568, v=120, color=8; final hold -> game_won=1.

Source files
------------

// File: rtl/level_sequencer.sv
// Game-level controller: places the destination rectangle for each level, runs the
// inter-level hold, re-arms the player and flags the win after the last level.
module level_sequencer #(
  parameter int NUM_LEVELS  = 8,
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       level_complete,
  output logic [9:0] vStartPos,
  output logic [9:0] hStartPos,
  output logic [3:0] rect_color,
  output logic       visible,
  output logic [3:0] level,
  output logic       player_reset,
  output logic       in_transition,
  output logic       game_won
);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       next_level;

  // Levels 8..15 reuse the position table of level L-8; colour keeps the full index.
  function automatic logic [9:0] h_of(input logic [3:0] l);
    return 10'd64 + 10'(l[2:0]) * 10'd72;
  endfunction

  function automatic logic [9:0] v_of(input logic [3:0] l);
    return 10'd400 - 10'(l[2:0]) * 10'd40;
  endfunction

  assign next_level = level + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      level         <= 4'd0;
      hold_cnt      <= '0;
      hStartPos     <= 10'd64;
      vStartPos     <= 10'd400;
      rect_color    <= 4'd1;
      visible       <= 1'b0;
      player_reset  <= 1'b0;
      in_transition <= 1'b0;
      game_won      <= 1'b0;
    end else begin
      player_reset <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= PLAY;
            level        <= 4'd0;
            hStartPos    <= h_of(4'd0);
            vStartPos    <= v_of(4'd0);
            rect_color   <= 4'd1;
            visible      <= 1'b1;
            player_reset <= 1'b1;
            game_won     <= 1'b0;
          end
        end
        PLAY: begin
          if (level_complete) begin
            state         <= HOLD;
            visible       <= 1'b0;
            in_transition <= 1'b1;
            hold_cnt      <= '0;
          end
        end
        HOLD: begin
          // Completion pulses are deliberately not latched here, even on the exit edge.
          if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            in_transition <= 1'b0;
            if (level < 4'(NUM_LEVELS - 1)) begin
              state        <= PLAY;
              level        <= next_level;
              hStartPos    <= h_of(next_level);
              vStartPos    <= v_of(next_level);
              rect_color   <= next_level + 4'd1;
              visible      <= 1'b1;
              player_reset <= 1'b1;
            end else begin
              state    <= DONE;
              game_won <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          level         <= 4'd0;
          hold_cnt      <= '0;
          hStartPos     <= 10'd64;
          vStartPos     <= 10'd400;
          rect_color    <= 4'd1;
          visible       <= 1'b0;
          player_reset  <= 1'b0;
          in_transition <= 1'b0;
          game_won      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench: a 3-level / 4-cycle-hold instance for the sequencing scenarios and
// an 8-level instance for the last-table-entry and final-win checks.
module tb_level_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic level_complete = 1'b0;
  logic start_b = 1'b0;
  logic level_complete_b = 1'b0;

  logic [9:0] v_pos, h_pos, v_pos_b, h_pos_b;
  logic [3:0] color, color_b, lvl, lvl_b;
  logic       vis, vis_b, pr, pr_b, it, it_b, won, won_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  level_sequencer #(.NUM_LEVELS(3), .HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .level_complete(level_complete),
    .vStartPos(v_pos), .hStartPos(h_pos), .rect_color(color), .visible(vis),
    .level(lvl), .player_reset(pr), .in_transition(it), .game_won(won)
  );

  level_sequencer #(.NUM_LEVELS(8), .HOLD_CYCLES(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .level_complete(level_complete_b),
    .vStartPos(v_pos_b), .hStartPos(h_pos_b), .rect_color(color_b), .visible(vis_b),
    .level(lvl_b), .player_reset(pr_b), .in_transition(it_b), .game_won(won_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic lc);
    start = s;
    level_complete = lc;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int e_vis, input int e_lvl, input int e_h,
                          input int e_v, input int e_col, input int e_pr, input int e_it,
                          input int e_won);
    checkOutput({tag, ".visible"}, int'(vis), e_vis);
    checkOutput({tag, ".level"}, int'(lvl), e_lvl);
    checkOutput({tag, ".h"}, int'(h_pos), e_h);
    checkOutput({tag, ".v"}, int'(v_pos), e_v);
    checkOutput({tag, ".color"}, int'(color), e_col);
    checkOutput({tag, ".player_reset"}, int'(pr), e_pr);
    checkOutput({tag, ".in_transition"}, int'(it), e_it);
    checkOutput({tag, ".game_won"}, int'(won), e_won);
  endtask

  // Pulse level_complete, then walk the 4 hold cycles; lc_at selects a hold cycle
  // (1..4) in which a stray completion pulse is injected, 0 for none.
  task automatic runHold(input string tag, input int lc_at);
    applyStimulus(1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      checkOutput({tag, ".hold_vis"}, int'(vis), 0);
      checkOutput({tag, ".hold_it"}, int'(it), 1);
      applyStimulus(1'b0, (i == lc_at));
      tick();
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] level_sequencer directed test");
    tick();
    tick();
    rst = 1'b1;
    checkAll("reset", 0, 0, 64, 400, 1, 0, 0, 0);

    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkAll("idle_lc", 0, 0, 64, 400, 1, 0, 0, 0);

    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkAll("start", 1, 0, 64, 400, 1, 1, 0, 0);
    tick();
    checkOutput("start.pr_one_cycle", int'(pr), 0);

    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkAll("play_start", 1, 0, 64, 400, 1, 0, 0, 0);

    runHold("adv0", 2);
    checkAll("level1", 1, 1, 136, 360, 2, 1, 0, 0);
    tick();
    checkOutput("level1.pr_one_cycle", int'(pr), 0);

    runHold("adv1", 4);
    checkAll("level2", 1, 2, 208, 320, 3, 1, 0, 0);
    tick();
    checkAll("drop_lc", 1, 2, 208, 320, 3, 0, 0, 0);

    runHold("adv2", 0);
    checkAll("won", 0, 2, 208, 320, 3, 0, 0, 1);
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkAll("done_lc", 0, 2, 208, 320, 3, 0, 0, 1);

    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkAll("restart", 1, 0, 64, 400, 1, 1, 0, 0);
    tick();

    runHold("adv0b", 0);
    checkAll("level1b", 1, 1, 136, 360, 2, 1, 0, 0);
    tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("midreset.pre_it", int'(it), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkAll("midreset", 0, 0, 64, 400, 1, 0, 0, 0);
    tick();
    checkAll("midreset_idle", 0, 0, 64, 400, 1, 0, 0, 0);

    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checkOutput("b.start_vis", int'(vis_b), 1);
    for (int l = 1; l <= 7; l++) begin
      level_complete_b = 1'b1;
      tick();
      level_complete_b = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("b.level", int'(lvl_b), l);
    end
    checkOutput("b.l7_h", int'(h_pos_b), 568);
    checkOutput("b.l7_v", int'(v_pos_b), 120);
    checkOutput("b.l7_color", int'(color_b), 8);
    checkOutput("b.l7_vis", int'(vis_b), 1);
    level_complete_b = 1'b1;
    tick();
    level_complete_b = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("b.won", int'(won_b), 1);
    checkOutput("b.won_vis", int'(vis_b), 0);
    checkOutput("b.won_level", int'(lvl_b), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
